gapbuf_prefetch: RTL and testbench
==================================

// Module: gapbuf_prefetch
// PURPOSE
//  Parametrised successor of the CES gap buffer. Stores a write-valid stream in
//  a 2^ADD-entry RAM FIFO, prefetches through a configurable RAM read latency
//  into a PFDEP-deep register FIFO, and presents words on an oreq/iget request
//  handshake. Adds back-to-back output mode, almost-full flag, overflow sticky
//  and a saturating drop counter. Sits between CES packet writers and readers.
// PARAMETERS
//  ADD       4     log2 of RAM FIFO depth (DEPTH = 2^ADD)
//  INFO      32    data width
//  RDLAT     2     RAM read latency in clk cycles, 1..4
//  PFDEP     2     prefetch register FIFO depth, power of 2, 2..8
//  AFTHR     12    oafull threshold on ovldlen, 1..DEPTH
//  BACK2BACK 0     0 = bubble after each iget, 1 = one word per clk
// PORTS
//  clk       in   1       clock
//  rst       in   1       reset; synchronous, active-high
//  ivld      in   1       write strobe
//  ivldinfo  in   INFO    write data
//  ovldfull  out  1       ovldlen == DEPTH
//  oafull    out  1       ovldlen >= AFTHR
//  ovldlen   out  ADD+1   words accepted but not yet taken
//  flush     in   1       flush request
//  oreq      out  1       oreqinfo valid, held until iget
//  oreqinfo  out  INFO    head word
//  iget      in   1       reader takes head word; valid only with oreq=1
//  oovf      out  1       sticky: write dropped while full
//  odropcnt  out  16      saturating count of dropped writes
// BEHAVIOUR
//  - Reset: all outputs 0. Flush pipe is set to 1, so internal clear holds for
//    2 cycles after rst deasserts.
//  - Clear: clear = flush delayed 2 clk (flush_d2). Clear zeroes RAM pointers,
//    in-flight reads, prefetch FIFO, oreq and ovldlen. oovf/odropcnt are NOT
//    cleared; only rst clears them. ivld during clear is ignored and not counted.
//  - Write: ivld & !ovldfull writes RAM and increments ovldlen.
//  - Drop: ivld & ovldfull drops the word, sets oovf and increments odropcnt.
//    odropcnt saturates at 16'hFFFF.
//  - ovldlen decrement: decrements one cycle after iget & oreq (registered get).
//    Therefore ivld with iget in the same cycle at full is still dropped.
//  - Simultaneous: inc and dec in the same cycle leaves ovldlen unchanged.
//  - Prefetch: read issued when RAM non-empty & (inflight + pfcount) < PFDEP.
//    Data is pushed to the prefetch FIFO RDLAT cycles after issue; the prefetch
//    FIFO never overflows by construction. Pointers wrap modulo DEPTH / PFDEP.
//  - Output load: when oreq=0 & pf non-empty, the head is popped into oreqinfo
//    and oreq=1 on the next cycle.
//  - oreq holding: while oreq=1 & iget=0, oreq and oreqinfo are held stable.
//  - iget, BACK2BACK=0: oreq drops for >= 1 cycle after iget.
//  - iget, BACK2BACK=1: if pf non-empty, the next word loads on the same edge
//    and oreq stays 1; otherwise oreq drops.
//  - iget with oreq=0 is ignored.
//  - Latency: ivld in cycle 0 into an empty block gives oreq=1 in cycle RDLAT+3.
//  - Ordering: strict FIFO order; no word is duplicated or lost except by drop
//    or flush.
// TESTING
//  - Single word: ivld=1 in cycle 0, RDLAT=2 -> oreq=1 in cycle 5 with the data;
//    iget -> ovldlen 1->0 one cycle later.
//  - Fill 16 words with iget=0 -> ovldfull=1, ovldlen=16, oafull=1 from
//    ovldlen 12; 17th ivld -> oovf=1, odropcnt=1, data unchanged.
//  - Burst of 8, iget held 1: BACK2BACK=0 -> 8 words over 16 cycles;
//    BACK2BACK=1 -> 8 consecutive cycles with oreq=1, in order.
//  - Flush with 5 words stored and reads in flight -> oreq=0 and ovldlen=0 two
//    cycles after flush; next ivld is delivered alone; oovf unchanged.
//  - Pointer wrap: 40 words with random ivld/iget, RDLAT in {1,4}, PFDEP in
//    {2,8} -> scoreboard match, no drops while !ovldfull.
//  - Reset mid-burst: all outputs 0; ivld ignored for 2 cycles after rst falls.

Source files
------------

// File: rtl/gapbuf_prefetch_if.sv
// gapbuf_prefetch_if: write stream, flags and oreq/iget read handshake of the gap buffer
interface gapbuf_prefetch_if #(
  parameter int ADD = 4,
  parameter int INFO = 32
) ();
  logic ivld;
  logic [INFO-1:0] ivldinfo;
  logic ovldfull;
  logic oafull;
  logic [ADD:0] ovldlen;
  logic flush;
  logic oreq;
  logic [INFO-1:0] oreqinfo;
  logic iget;
  logic oovf;
  logic [15:0] odropcnt;
  modport master (
    output ivld, ivldinfo, flush, iget,
    input ovldfull, oafull, ovldlen, oreq, oreqinfo, oovf, odropcnt
  );
  modport slave (
    input ivld, ivldinfo, flush, iget,
    output ovldfull, oafull, ovldlen, oreq, oreqinfo, oovf, odropcnt
  );
endinterface

// File: rtl/gapbuf_prefetch.sv
// gapbuf_prefetch: RAM FIFO gap buffer with pipelined prefetch into an oreq/iget output stage
module gapbuf_prefetch #(
  parameter int ADD = 4,
  parameter int INFO = 32,
  parameter int RDLAT = 2,
  parameter int PFDEP = 2,
  parameter int AFTHR = 12,
  parameter int BACK2BACK = 0
) (
  input logic clk,
  input logic rst,
  gapbuf_prefetch_if.slave bus
);
  localparam int DEPTH = 1 << ADD;
  localparam int PW = $clog2(PFDEP);
  localparam logic [ADD:0] DEPTH_L = (ADD+1)'(DEPTH);
  localparam logic [ADD:0] AFTHR_L = (ADD+1)'(AFTHR);
  logic [INFO-1:0] ram [DEPTH];
  logic [INFO-1:0] pf_mem [PFDEP];
  logic [INFO-1:0] pd_q [RDLAT];
  logic [INFO-1:0] pd_d [RDLAT];
  logic [RDLAT-1:0] pv_q, pv_d;
  logic [ADD:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, len_q, len_d;
  logic [PW:0] pf_wr_q, pf_wr_d, pf_rd_q, pf_rd_d, pf_cnt;
  logic [INFO-1:0] info_q, info_d;
  logic [15:0] cnt_q, cnt_d;
  logic flush1_q, flush1_d, clear_q, clear_d, get_q, get_d;
  logic oreq_q, oreq_d, oovf_q, oovf_d;
  logic full, wr, drop, issue, push, take, load;
  int busy;
  assign full = len_q == DEPTH_L;
  assign wr = bus.ivld & ~full & ~clear_q;
  assign drop = bus.ivld & full & ~clear_q;
  assign pf_cnt = pf_wr_q - pf_rd_q;
  // reads in flight plus buffered words bound the prefetch FIFO, so it cannot overflow
  assign busy = $countones(pv_q) + int'(pf_cnt);
  assign issue = ~clear_q & (wr_ptr_q != rd_ptr_q) & (busy < PFDEP);
  assign push = pv_q[RDLAT-1] & ~clear_q;
  assign take = oreq_q & bus.iget;
  assign load = ~clear_q & (pf_cnt != '0) & (~oreq_q | (BACK2BACK != 0 && take));
  always_comb begin
    flush1_d = bus.flush;
    clear_d = flush1_q;
    wr_ptr_d = clear_q ? '0 : wr_ptr_q + {{ADD{1'b0}}, wr};
    rd_ptr_d = clear_q ? '0 : rd_ptr_q + {{ADD{1'b0}}, issue};
    len_d = clear_q ? '0 : len_q + {{ADD{1'b0}}, wr} - {{ADD{1'b0}}, get_q};
    get_d = take & ~clear_q;
    pv_d = clear_q ? '0 : (pv_q << 1) | RDLAT'(issue);
    pd_d[0] = ram[rd_ptr_q[ADD-1:0]];
    for (int i = 1; i < RDLAT; i++) pd_d[i] = pd_q[i-1];
    pf_wr_d = clear_q ? '0 : pf_wr_q + {{PW{1'b0}}, push};
    pf_rd_d = clear_q ? '0 : pf_rd_q + {{PW{1'b0}}, load};
    oreq_d = clear_q ? 1'b0 : load ? 1'b1 : take ? 1'b0 : oreq_q;
    info_d = load ? pf_mem[pf_rd_q[PW-1:0]] : info_q;
    oovf_d = oovf_q | drop;
    cnt_d = cnt_q + {15'd0, drop && cnt_q != 16'hFFFF};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      flush1_q <= 1'b1;
      clear_q <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      len_q <= '0;
      get_q <= 1'b0;
      pv_q <= '0;
      for (int i = 0; i < RDLAT; i++) pd_q[i] <= '0;
      pf_wr_q <= '0;
      pf_rd_q <= '0;
      oreq_q <= 1'b0;
      info_q <= '0;
      oovf_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      flush1_q <= flush1_d;
      clear_q <= clear_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      len_q <= len_d;
      get_q <= get_d;
      pv_q <= pv_d;
      pd_q <= pd_d;
      pf_wr_q <= pf_wr_d;
      pf_rd_q <= pf_rd_d;
      oreq_q <= oreq_d;
      info_q <= info_d;
      oovf_q <= oovf_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) if (wr) ram[wr_ptr_q[ADD-1:0]] <= bus.ivldinfo;
  always_ff @(posedge clk) if (push) pf_mem[pf_wr_q[PW-1:0]] <= pd_q[RDLAT-1];
  assign bus.ovldlen = len_q;
  assign bus.ovldfull = full;
  assign bus.oafull = len_q >= AFTHR_L;
  assign bus.oreq = oreq_q;
  assign bus.oreqinfo = info_q;
  assign bus.oovf = oovf_q;
  assign bus.odropcnt = cnt_q;
endmodule

// File: tb/tb_gapbuf_prefetch.sv
// tb_gapbuf_prefetch: three parameter sets driven in lockstep, scoreboard plus directed timing checks
module tb_gapbuf_prefetch;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ivld = 1'b0, flush = 1'b0, iget = 1'b0;
  logic [31:0] ivldinfo = '0;
  always #5 clk = ~clk;

  gapbuf_prefetch_if #(.ADD(4), .INFO(32)) bus_if [3] ();
  logic oreq_w [3], full_w [3], afull_w [3], ovf_w [3];
  logic [31:0] info_w [3];
  logic [4:0] len_w [3];
  logic [15:0] cnt_w [3];
  for (genvar g = 0; g < 3; g++) begin : g_bus
    assign bus_if[g].ivld = ivld;
    assign bus_if[g].ivldinfo = ivldinfo;
    assign bus_if[g].flush = flush;
    assign bus_if[g].iget = iget;
    assign oreq_w[g] = bus_if[g].oreq;
    assign info_w[g] = bus_if[g].oreqinfo;
    assign len_w[g] = bus_if[g].ovldlen;
    assign full_w[g] = bus_if[g].ovldfull;
    assign afull_w[g] = bus_if[g].oafull;
    assign ovf_w[g] = bus_if[g].oovf;
    assign cnt_w[g] = bus_if[g].odropcnt;
  end

  gapbuf_prefetch #(.ADD(4), .INFO(32), .RDLAT(2), .PFDEP(2), .AFTHR(12), .BACK2BACK(0))
    u0 (.clk(clk), .rst(rst), .bus(bus_if[0]));
  gapbuf_prefetch #(.ADD(4), .INFO(32), .RDLAT(4), .PFDEP(8), .AFTHR(12), .BACK2BACK(1))
    u1 (.clk(clk), .rst(rst), .bus(bus_if[1]));
  gapbuf_prefetch #(.ADD(4), .INFO(32), .RDLAT(1), .PFDEP(2), .AFTHR(12), .BACK2BACK(0))
    u2 (.clk(clk), .rst(rst), .bus(bus_if[2]));

  int lat [3] = '{5, 7, 4};
  int span [3] = '{14, 7, 14};
  int n_tests = 0, n_fail = 0;

  logic [31:0] sbq [3][$];
  int mlen [3];
  bit movf [3], pend [3], take_seen [3], hold_p [3];
  logic [15:0] mcnt [3];
  logic [31:0] hold_i [3];
  bit started = 0, f1 = 0, f2 = 0, edge_clr = 0;

  task automatic chk(string nm, int k, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s u%0d got 0x%0h want 0x%0h", nm, k, act, exp);
    end
  endtask

  // reference model: advances on each edge from the bench-driven inputs
  always @(posedge clk) begin
    bit acc;
    if (rst) begin
      started = 1; f1 = 1; f2 = 1; edge_clr = 1;
      for (int k = 0; k < 3; k++) begin
        sbq[k].delete(); mlen[k] = 0; movf[k] = 0; mcnt[k] = '0; pend[k] = 0;
      end
    end else begin
      edge_clr = f2; f2 = f1; f1 = flush;
      for (int k = 0; k < 3; k++) begin
        if (edge_clr) begin
          sbq[k].delete(); mlen[k] = 0; pend[k] = 0;
        end else begin
          acc = ivld && mlen[k] < 16;
          if (acc) sbq[k].push_back(ivldinfo);
          else if (ivld) begin
            movf[k] = 1;
            if (mcnt[k] != 16'hFFFF) mcnt[k]++;
          end
          mlen[k] = mlen[k] + int'(acc) - int'(pend[k]);
          pend[k] = take_seen[k];
        end
      end
    end
  end

  // monitor: compares outputs mid-cycle and pops the scoreboard on every take
  always @(negedge clk) if (started) begin
    for (int k = 0; k < 3; k++) begin
      chk("ovldlen", k, 32'(len_w[k]), 32'(mlen[k]));
      chk("ovldfull", k, 32'(full_w[k]), 32'(mlen[k] == 16));
      chk("oafull", k, 32'(afull_w[k]), 32'(mlen[k] >= 12));
      chk("oovf", k, 32'(ovf_w[k]), 32'(movf[k]));
      chk("odropcnt", k, 32'(cnt_w[k]), 32'(mcnt[k]));
      if (hold_p[k] && !edge_clr) begin
        chk("hold_oreq", k, 32'(oreq_w[k]), 32'd1);
        chk("hold_info", k, info_w[k], hold_i[k]);
      end
      if (oreq_w[k] && iget) begin
        if (sbq[k].size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL extra_word u%0d got 0x%0h want none", k, info_w[k]);
        end else chk("data", k, info_w[k], sbq[k].pop_front());
      end
      take_seen[k] = oreq_w[k] && iget;
      hold_p[k] = oreq_w[k] && !iget;
      hold_i[k] = info_w[k];
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drain(int n);
    iget = 1'b1;
    repeat (n) tick();
    iget = 1'b0;
  endtask

  task automatic chk_idle(string nm);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk({nm, "_len"}, k, 32'(len_w[k]), 32'd0);
      chk({nm, "_oreq"}, k, 32'(oreq_w[k]), 32'd0);
      chk({nm, "_sb"}, k, sbq[k].size(), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int first [3], last [3], nt [3];
    logic [31:0] d;
    repeat (3) tick();
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("rst_oreq", k, 32'(oreq_w[k]), 32'd0);
      chk("rst_info", k, info_w[k], 32'd0);
      chk("rst_len", k, 32'(len_w[k]), 32'd0);
      chk("rst_cnt", k, 32'(cnt_w[k]), 32'd0);
    end
    tick();
    rst = 0; ivld = 1; ivldinfo = 32'hDEAD0001;
    tick();
    ivldinfo = 32'hDEAD0002;
    tick();
    ivld = 0;
    repeat (8) tick();
    chk_idle("clear_ign");
    // single word latency
    tick();
    d = 32'hA5A50001; ivld = 1; ivldinfo = d;
    for (int c = 1; c < 8; c++) begin
      tick();
      ivld = 0;
      @(negedge clk);
      for (int k = 0; k < 3; k++) chk("lat_oreq", k, 32'(oreq_w[k]), 32'(c >= lat[k]));
    end
    for (int k = 0; k < 3; k++) chk("lat_info", k, info_w[k], d);
    tick(); iget = 1;
    tick(); iget = 0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("get_len1", k, 32'(len_w[k]), 32'd1);
      chk("get_oreq", k, 32'(oreq_w[k]), 32'd0);
    end
    tick();
    @(negedge clk);
    for (int k = 0; k < 3; k++) chk("get_len0", k, 32'(len_w[k]), 32'd0);
    // fill to full, then drop twice (second with a simultaneous iget)
    for (int i = 0; i < 16; i++) begin
      tick();
      ivld = 1; ivldinfo = $urandom;
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        chk("fill_len", k, 32'(len_w[k]), 32'(i));
        chk("fill_afull", k, 32'(afull_w[k]), 32'(i >= 12));
      end
    end
    tick();
    ivldinfo = 32'hBAD00017;
    @(negedge clk);
    for (int k = 0; k < 3; k++) chk("full_flag", k, 32'(full_w[k]), 32'd1);
    tick(); iget = 1; ivldinfo = 32'hBAD00018;
    tick(); iget = 0; ivld = 0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("drop_ovf", k, 32'(ovf_w[k]), 32'd1);
      chk("drop_cnt", k, 32'(cnt_w[k]), 32'd2);
      chk("drop_len", k, 32'(len_w[k]), 32'd16);
    end
    tick();
    drain(50);
    chk_idle("fill_drain");
    // burst of 8 with iget held
    tick();
    iget = 1;
    for (int k = 0; k < 3; k++) begin first[k] = -1; last[k] = -1; nt[k] = 0; end
    for (int c = 0; c < 40; c++) begin
      ivld = c < 8; ivldinfo = $urandom;
      @(negedge clk);
      for (int k = 0; k < 3; k++) if (oreq_w[k]) begin
        nt[k]++;
        if (first[k] < 0) first[k] = c;
        last[k] = c;
      end
      tick();
    end
    iget = 0;
    for (int k = 0; k < 3; k++) begin
      chk("burst_cnt", k, nt[k], 32'd8);
      chk("burst_span", k, last[k] - first[k], span[k]);
    end
    // flush with reads in flight
    for (int c = 0; c < 5; c++) begin
      ivld = 1; ivldinfo = $urandom;
      tick();
    end
    ivld = 0; flush = 1;
    tick(); flush = 0;
    tick(); tick();
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("flush_oreq", k, 32'(oreq_w[k]), 32'd0);
      chk("flush_len", k, 32'(len_w[k]), 32'd0);
      chk("flush_ovf", k, 32'(ovf_w[k]), 32'd1);
    end
    repeat (10) tick();
    chk_idle("flush_quiet");
    tick();
    ivld = 1; ivldinfo = 32'h5EC0D001;
    tick(); ivld = 0;
    repeat (10) tick();
    drain(10);
    repeat (3) tick();
    chk_idle("flush_after");
    // random traffic across many pointer wraps
    for (int c = 0; c < 500; c++) begin
      ivld = $urandom_range(0, 99) < 55;
      ivldinfo = $urandom;
      iget = $urandom_range(0, 99) < 50;
      tick();
    end
    ivld = 0;
    drain(80);
    repeat (3) tick();
    chk_idle("rand_drain");
    // reset in the middle of a burst
    for (int c = 0; c < 6; c++) begin
      ivld = 1; ivldinfo = $urandom;
      tick();
    end
    rst = 1;
    tick(); tick();
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("mrst_oreq", k, 32'(oreq_w[k]), 32'd0);
      chk("mrst_info", k, info_w[k], 32'd0);
      chk("mrst_len", k, 32'(len_w[k]), 32'd0);
      chk("mrst_ovf", k, 32'(ovf_w[k]), 32'd0);
      chk("mrst_cnt", k, 32'(cnt_w[k]), 32'd0);
      chk("mrst_full", k, 32'(full_w[k]), 32'd0);
    end
    tick();
    rst = 0; ivldinfo = 32'hC1EA0001;
    tick(); ivldinfo = 32'hC1EA0002;
    tick(); ivld = 0;
    repeat (8) tick();
    chk_idle("mrst_ign");
    tick();
    ivld = 1; ivldinfo = 32'h600D0001;
    tick(); ivld = 0;
    repeat (10) tick();
    drain(5);
    repeat (3) tick();
    chk_idle("mrst_after");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
